score_digits_ctrl: RTL and testbench
====================================

// Module: score_digits_ctrl
// PURPOSE
//  Sequencer for the 16x32 digit bitmap renderer. Accepts a binary score on a load pulse.
//  Converts it to BCD with a sequential double-dabble. Commits the new digits only at a frame boundary, so no digit tears.
//  For every VGA pixel, selects the digit slot under it and drives the renderer's digit/offset/inside inputs.
//  Sits between game logic (score source) and the digit bitmap in the VGA object path.
// PARAMETERS
//  NUM_DIGITS     4    digit slots, slot 0 = leftmost = most significant
//  VALUE_W        14   width of binary input value
//  TOPLEFT_X      16   screen X of slot 0 left edge
//  TOPLEFT_Y      16   screen Y of digit row top edge
//  DIGIT_W        16   slot width in pixels; power of 2 (enforced by elaboration check)
//  DIGIT_H        32   slot height in pixels
//  BLANK_LEADING  1    1: suppress leading zeros (rightmost digit always shown)
// PORTS
//  clk             in   1              pixel clock
//  resetN          in   1              async active-low reset
//  load            in   1              1-cycle pulse: capture value
//  value           in   VALUE_W        binary score
//  startOfFrame    in   1              1-cycle pulse at frame start
//  pixelX          in   11             current pixel X
//  pixelY          in   11             current pixel Y
//  busy            out  1              conversion/commit in progress
//  done            out  1              1-cycle pulse on commit
//  digit           out  4              BCD digit for renderer
//  offsetX         out  11             X offset inside slot, 0..DIGIT_W-1
//  offsetY         out  11             Y offset inside slot, 0..DIGIT_H-1
//  InsideRectangle out  1              pixel is inside a visible slot
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, committed digits all 0. digit, offsetX, offsetY and InsideRectangle are 0.
//  FSM IDLE -> SHIFT -> WAIT_FRAME -> IDLE.
//   IDLE: on load, capture value; go to SHIFT. busy=1 from the next cycle.
//   SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left 1 with the next value MSB.
//   WAIT_FRAME: hold result. On startOfFrame, copy it to the committed digits, pulse done, return to IDLE. busy=0 the cycle after commit.
//  load while busy is ignored: no queueing, the value is dropped.
//  Saturation: value > 10^NUM_DIGITS-1 commits all 9s. BCD scratch holds ceil(VALUE_W*1.21/4)+1 nibbles. The check is made on the captured value.
//  startOfFrame in IDLE or SHIFT has no effect on committed digits.
//  startOfFrame coincident with the last SHIFT cycle is not used; commit waits for the next frame.
//  Pixel path, one registered stage (latency 1 from pixelX/Y). The downstream renderer adds 1 more, so 2 in total:
//   relX = pixelX-TOPLEFT_X, relY = pixelY-TOPLEFT_Y, computed as 11-bit unsigned.
//   in = pixelX>=TOPLEFT_X && relX<NUM_DIGITS*DIGIT_W && pixelY>=TOPLEFT_Y && relY<DIGIT_H
//   slot = relX>>log2(DIGIT_W); offsetX = relX & (DIGIT_W-1); offsetY = relY; digit = committed[slot]
//   Blanking: with BLANK_LEADING, slot s<NUM_DIGITS-1 is blank when all digits of slots 0..s are 0.
//   A blank slot forces InsideRectangle=0; digit and offsets are still driven.
//   Outside: InsideRectangle=0, digit=0, offsetX=0, offsetY=0.
//  Pixel path reads only committed digits and never scratch BCD. Display changes only at frame start.
//  Reset mid-conversion: all state is cleared and the display shows 0. The pending load is lost.
// STRUCTURE
//  score_pkg: typedef enum {IDLE,SHIFT,WAIT_FRAME} score_state_t. Also bcd_digit_t (logic[3:0]), PIXEL_W=11, MAX_DIGIT=4'd9.
//  Sub-module bin2bcd_seq handles the capture, shift counter and add-3 network. Ports: start, bin, busy, valid, bcd[], ovf.
//  score_digits_ctrl holds the FSM's WAIT_FRAME/commit, the committed register, blanking and the pixel path.
// TESTING
//  Reset, then load value=1234, startOfFrame 30 cycles later -> busy high 14 shift cycles + wait; done at SOF; digits 1,2,3,4.
//  Load 20000 (VALUE_W=15 build) or 16383 -> committed 9,9,9,9.
//  Load 7 with BLANK_LEADING=1 -> pixels in slots 0-2 give InsideRectangle=0; slot 3 gives digit=7.
//  Pixel sweep: pixelX=47,pixelY=20 -> 1 cycle later slot 1, offsetX=15, offsetY=4, inside=1. pixelX=80 or pixelY=48 -> inside=0.
//  Second load during SHIFT -> ignored; committed value is the first. Two SOFs while in SHIFT -> display unchanged until WAIT_FRAME.
//  resetN low during SHIFT -> busy=0, digits 0 immediately (async); next load converts normally.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and helpers for the score digit sequencer.
package score_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_FRAME} score_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned PIXEL_W   = 11;
   localparam bcd_digit_t  MAX_DIGIT = 4'd9;

   // Double-dabble correction applied to a nibble before each shift.
   function automatic bcd_digit_t dabble(input bcd_digit_t d);
      return (d >= 4'd5) ? 4'(d + 4'd3) : d;
   endfunction

   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/score_digits_ctrl_bin2bcd.sv
// Sequential binary-to-BCD converter: one double-dabble step per clock.
module bin2bcd_seq
   import score_pkg::*;
#(
   parameter int unsigned VALUE_W    = 14,
   parameter int unsigned NUM_DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          start,
   input  logic [VALUE_W-1:0]            bin,
   output logic                          busy,
   output logic                          valid,
   output bcd_digit_t [NUM_DIGITS-1:0]   bcd,
   output logic                          ovf
);

   localparam int unsigned BCD_N   = (VALUE_W * 121 + 399) / 400 + 1;
   localparam int unsigned CAT_W   = BCD_N * 4 + VALUE_W;
   localparam int unsigned CNT_W   = $clog2(VALUE_W + 1);
   localparam int unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

   logic [VALUE_W-1:0]       sh_q;
   bcd_digit_t [BCD_N-1:0]   scr_q;
   bcd_digit_t [BCD_N-1:0]   scr_adj;
   logic [CNT_W-1:0]         cnt_q;
   logic [CAT_W-1:0]         cat_sh;

   // Add-3 network followed by a one-bit shift of {scratch, remaining bits}.
   always_comb begin
      scr_adj = '0;
      for (int i = 0; i < int'(BCD_N); i++) scr_adj[i] = dabble(scr_q[i]);
      cat_sh = {scr_adj, sh_q} << 1;
   end

   assign bcd = scr_q[NUM_DIGITS-1:0];

   // valid marks the final shift cycle; scratch holds the full result after it.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sh_q  <= '0;
         scr_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
         valid <= 1'b0;
         ovf   <= 1'b0;
      end else if (start && !busy) begin
         sh_q  <= bin;
         scr_q <= '0;
         cnt_q <= CNT_W'(VALUE_W);
         busy  <= 1'b1;
         valid <= (VALUE_W == 1);
         ovf   <= (32'(bin) > MAX_VAL);
      end else if (busy) begin
         scr_q <= cat_sh[CAT_W-1:VALUE_W];
         sh_q  <= cat_sh[VALUE_W-1:0];
         cnt_q <= cnt_q - CNT_W'(1);
         busy  <= (cnt_q != CNT_W'(1));
         valid <= (cnt_q == CNT_W'(2));
      end else begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/score_digits_ctrl.sv
// Score digit sequencer: converts a loaded score, commits it at frame start, drives the digit renderer.
module score_digits_ctrl
   import score_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned VALUE_W       = 14,
   parameter int unsigned TOPLEFT_X     = 16,
   parameter int unsigned TOPLEFT_Y     = 16,
   parameter int unsigned DIGIT_W       = 16,
   parameter int unsigned DIGIT_H       = 32,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               load,
   input  logic [VALUE_W-1:0] value,
   input  logic               startOfFrame,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   output logic               busy,
   output logic               done,
   output logic [3:0]         digit,
   output logic [10:0]        offsetX,
   output logic [10:0]        offsetY,
   output logic               InsideRectangle
);

   localparam int unsigned DW_LOG = $clog2(DIGIT_W);
   localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   if ((DIGIT_W & (DIGIT_W - 1)) != 0) begin : g_bad_digit_w
      $error("DIGIT_W must be a power of 2");
   end

   score_state_t                 state_q, state_d;
   logic                         commit_c;
   logic                         cvt_start_c;
   logic                         cvt_busy, cvt_valid, cvt_ovf;
   bcd_digit_t [NUM_DIGITS-1:0]  cvt_bcd;
   bcd_digit_t [NUM_DIGITS-1:0]  committed_q;
   bcd_digit_t [NUM_DIGITS-1:0]  commit_val_c;
   logic [NUM_DIGITS-1:0]        blank_c;

   assign cvt_start_c = load && (state_q == IDLE);

   bin2bcd_seq #(
      .VALUE_W   (VALUE_W),
      .NUM_DIGITS(NUM_DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .resetN(resetN),
      .start (cvt_start_c),
      .bin   (value),
      .busy  (cvt_busy),
      .valid (cvt_valid),
      .bcd   (cvt_bcd),
      .ovf   (cvt_ovf)
   );

   // Next-state logic; commit only on a frame boundary after conversion finished.
   always_comb begin
      state_d  = state_q;
      commit_c = 1'b0;
      case (state_q)
         IDLE:       if (load) state_d = SHIFT;
         SHIFT:      if (cvt_busy && cvt_valid) state_d = WAIT_FRAME;
         WAIT_FRAME: if (startOfFrame) begin
            commit_c = 1'b1;
            state_d  = IDLE;
         end
         default:    state_d = IDLE;
      endcase
   end

   // Slot 0 is the most significant digit; overflow saturates to all nines.
   always_comb begin
      commit_val_c = '0;
      for (int s = 0; s < int'(NUM_DIGITS); s++)
         commit_val_c[s] = cvt_ovf ? MAX_DIGIT : cvt_bcd[int'(NUM_DIGITS) - 1 - s];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         committed_q <= '0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         done    <= commit_c;
         if (commit_c) committed_q <= commit_val_c;
      end
   end

   // Leading-zero blanking; the rightmost slot is never blanked.
   always_comb begin
      logic zero_run;
      blank_c  = '0;
      zero_run = 1'b1;
      for (int s = 0; s < int'(NUM_DIGITS); s++) begin
         zero_run = zero_run && (committed_q[s] == 4'd0);
         if ((BLANK_LEADING != 0) && (s < int'(NUM_DIGITS) - 1)) blank_c[s] = zero_run;
      end
   end

   logic [PIXEL_W-1:0] rel_x_c, rel_y_c;
   logic               in_c;
   logic [SLOT_W-1:0]  slot_c;

   always_comb begin
      rel_x_c = pixelX - PIXEL_W'(TOPLEFT_X);
      rel_y_c = pixelY - PIXEL_W'(TOPLEFT_Y);
      in_c    = (pixelX >= PIXEL_W'(TOPLEFT_X)) && (rel_x_c < PIXEL_W'(NUM_DIGITS * DIGIT_W)) &&
                (pixelY >= PIXEL_W'(TOPLEFT_Y)) && (rel_y_c < PIXEL_W'(DIGIT_H));
      slot_c  = SLOT_W'(rel_x_c >> DW_LOG);
   end

   // Single registered pixel stage reading only committed digits.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         digit           <= '0;
         offsetX         <= '0;
         offsetY         <= '0;
         InsideRectangle <= 1'b0;
      end else if (in_c) begin
         digit           <= committed_q[slot_c];
         offsetX         <= rel_x_c & PIXEL_W'(DIGIT_W - 1);
         offsetY         <= rel_y_c;
         InsideRectangle <= !blank_c[slot_c];
      end else begin
         digit           <= '0;
         offsetX         <= '0;
         offsetY         <= '0;
         InsideRectangle <= 1'b0;
      end
   end

endmodule

// File: tb/tb_score_digits_ctrl.sv
// Self-checking bench for score_digits_ctrl: pixel table, corner sequences, randomized loads vs. arithmetic model.
module tb_score_digits_ctrl;

   logic        clk = 1'b0;
   logic        resetN, load, startOfFrame;
   logic [13:0] value;
   logic [10:0] pixelX, pixelY;
   logic        busy, done, InsideRectangle;
   logic [3:0]  digit;
   logic [10:0] offsetX, offsetY;

   int vectors     = 0;
   int miscompares = 0;
   int model_val   = 0;
   int bnd[6]      = '{0, 9, 10, 9999, 10000, 16383};

   typedef struct {
      int px;
      int py;
      int in_exp;
      int dig_exp;
      int ox_exp;
      int oy_exp;
   } pix_vec_t;

   pix_vec_t tbl[9];

   score_digits_ctrl dut (
      .clk            (clk),
      .resetN         (resetN),
      .load           (load),
      .value          (value),
      .startOfFrame   (startOfFrame),
      .pixelX         (pixelX),
      .pixelY         (pixelY),
      .busy           (busy),
      .done           (done),
      .digit          (digit),
      .offsetX        (offsetX),
      .offsetY        (offsetY),
      .InsideRectangle(InsideRectangle)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int pow10i(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   task automatic do_load(input int v);
      value = 14'(v);
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic sof_pulse();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   // Expected renderer inputs derived from screen geometry and the decimal score.
   task automatic check_pixel(input string name, input int px, input int py);
      int slot, ed, ein, eox, eoy;
      pixelX = 11'(px);
      pixelY = 11'(py);
      tick();
      ed = 0; ein = 0; eox = 0; eoy = 0;
      if (px >= 16 && px < 80 && py >= 16 && py < 48) begin
         slot = (px - 16) / 16;
         ed   = (model_val / pow10i(3 - slot)) % 10;
         ein  = (slot < 3 && model_val < pow10i(3 - slot)) ? 0 : 1;
         eox  = (px - 16) % 16;
         eoy  = py - 16;
      end
      chk({name, "_digit"},  32'(digit),           32'(ed));
      chk({name, "_inside"}, 32'(InsideRectangle), 32'(ein));
      chk({name, "_offx"},   32'(offsetX),         32'(eox));
      chk({name, "_offy"},   32'(offsetY),         32'(eoy));
   endtask

   task automatic check_display(input string name);
      for (int s = 0; s < 4; s++) check_pixel(name, 16 + 16 * s + 3, 17 + 7 * s);
   endtask

   task automatic convert(input string name, input int v, input int gap);
      do_load(v);
      chk({name, "_busy_load"}, 32'(busy), 32'd1);
      for (int i = 0; i < gap; i++) tick();
      chk({name, "_busy_wait"}, 32'(busy), 32'd1);
      chk({name, "_done_wait"}, 32'(done), 32'd0);
      sof_pulse();
      chk({name, "_done"},      32'(done), 32'd1);
      chk({name, "_busy_end"},  32'(busy), 32'd0);
      model_val = sat(v);
      tick();
      chk({name, "_done_drop"}, 32'(done), 32'd0);
   endtask

   initial begin
      resetN = 1'b0; load = 1'b0; startOfFrame = 1'b0;
      value = '0; pixelX = 11'd20; pixelY = 11'd20;

      tbl[0] = '{47, 20, 1, 2, 15, 4};
      tbl[1] = '{16, 16, 1, 1, 0, 0};
      tbl[2] = '{79, 47, 1, 4, 15, 31};
      tbl[3] = '{64, 30, 1, 4, 0, 14};
      tbl[4] = '{80, 20, 0, 0, 0, 0};
      tbl[5] = '{47, 48, 0, 0, 0, 0};
      tbl[6] = '{15, 20, 0, 0, 0, 0};
      tbl[7] = '{40, 15, 0, 0, 0, 0};
      tbl[8] = '{2047, 2047, 0, 0, 0, 0};

      // Reset state
      repeat (3) tick();
      chk("rst_busy",   32'(busy),            32'd0);
      chk("rst_done",   32'(done),            32'd0);
      chk("rst_digit",  32'(digit),           32'd0);
      chk("rst_offx",   32'(offsetX),         32'd0);
      chk("rst_offy",   32'(offsetY),         32'd0);
      chk("rst_inside", 32'(InsideRectangle), 32'd0);
      resetN = 1'b1;
      tick();
      check_display("rst_disp");

      // Basic conversion, busy held through shift and wait until the frame start
      do_load(1234);
      chk("c1234_busy_load", 32'(busy), 32'd1);
      for (int i = 0; i < 29; i++) begin
         tick();
         chk("c1234_busy", 32'(busy), 32'd1);
         chk("c1234_nodone", 32'(done), 32'd0);
      end
      sof_pulse();
      chk("c1234_done", 32'(done), 32'd1);
      chk("c1234_busy_end", 32'(busy), 32'd0);
      model_val = 1234;
      tick();
      chk("c1234_done_drop", 32'(done), 32'd0);
      check_display("c1234_disp");

      // Pixel geometry table against value 1234
      for (int i = 0; i < 9; i++) begin
         pixelX = 11'(tbl[i].px);
         pixelY = 11'(tbl[i].py);
         tick();
         chk("tbl_inside", 32'(InsideRectangle), 32'(tbl[i].in_exp));
         chk("tbl_digit",  32'(digit),           32'(tbl[i].dig_exp));
         chk("tbl_offx",   32'(offsetX),         32'(tbl[i].ox_exp));
         chk("tbl_offy",   32'(offsetY),         32'(tbl[i].oy_exp));
      end

      // Saturation boundaries
      convert("sat16383", 16383, 14); check_display("sat16383_disp");
      convert("sat10000", 10000, 20); check_display("sat10000_disp");
      convert("eq9999",   9999,  16); check_display("eq9999_disp");

      // Leading-zero blanking
      convert("blank7", 7, 15);
      check_display("blank7_disp");

      // Second load and frame starts during SHIFT are ignored
      do_load(5678);
      tick();
      sof_pulse();
      chk("sof_in_shift_done", 32'(done), 32'd0);
      do_load(4321);
      sof_pulse();
      chk("sof_in_shift_done2", 32'(done), 32'd0);
      check_pixel("shift_hold_disp", 67, 25);
      repeat (12) tick();
      sof_pulse();
      chk("dbl_load_done", 32'(done), 32'd1);
      model_val = 5678;
      tick();
      check_display("dbl_load_disp");

      // Frame start on the last SHIFT cycle does not commit
      do_load(42);
      repeat (13) tick();
      sof_pulse();
      chk("last_shift_sof_done", 32'(done), 32'd0);
      chk("last_shift_sof_busy", 32'(busy), 32'd1);
      tick();
      chk("last_shift_sof_done2", 32'(done), 32'd0);
      sof_pulse();
      chk("last_shift_next_done", 32'(done), 32'd1);
      model_val = 42;
      tick();
      check_display("last_shift_disp");

      // Asynchronous reset mid-conversion
      do_load(4321);
      repeat (5) tick();
      #2 resetN = 1'b0;
      #1;
      chk("arst_busy",   32'(busy),            32'd0);
      chk("arst_done",   32'(done),            32'd0);
      chk("arst_digit",  32'(digit),           32'd0);
      chk("arst_inside", 32'(InsideRectangle), 32'd0);
      model_val = 0;
      tick();
      resetN = 1'b1;
      check_display("arst_disp");
      convert("post_rst56", 56, 20);
      check_display("post_rst56_disp");

      // Randomized loads with ignored extra loads and early frame starts
      for (int it = 0; it < 40; it++) begin
         int v, other, gap, k_load, k_sof;
         case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(0, 99));
            1:       v = int'($urandom_range(0, 9999));
            2:       v = int'($urandom_range(0, 16383));
            default: v = bnd[$urandom_range(0, 5)];
         endcase
         other  = int'($urandom_range(0, 16383));
         gap    = int'($urandom_range(14, 30));
         k_load = int'($urandom_range(0, 12));
         k_sof  = int'($urandom_range(0, 12));
         do_load(v);
         for (int i = 0; i < gap; i++) begin
            if (i == k_load) begin
               value = 14'(other);
               load  = 1'b1;
               tick();
               load  = 1'b0;
            end else if (i == k_sof) begin
               sof_pulse();
            end else begin
               tick();
            end
         end
         chk("rand_busy", 32'(busy), 32'd1);
         chk("rand_nodone", 32'(done), 32'd0);
         sof_pulse();
         chk("rand_done", 32'(done), 32'd1);
         chk("rand_busy_end", 32'(busy), 32'd0);
         model_val = sat(v);
         for (int p = 0; p < 4; p++)
            check_pixel("rand_pix", int'($urandom_range(0, 90)), int'($urandom_range(10, 50)));
         check_pixel("rand_slot3", 70, 30);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
